// File: rtl/apb_cmd_master.sv
// APB requester: turns valid/ready commands into single APB transfers
// (SETUP then ACCESS with optional wait states) and returns one response
// pulse per transfer carrying read data, slave error and timeout status.
//
// state  | meaning
// IDLE   | no transfer in flight, cmd_ready high
// SETUP  | psel high, penable low, address/data launched
// ACCESS | psel and penable high, waiting for pready or timeout
module apb_cmd_master #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Count value seen on the last allowed wait cycle; only meaningful when
  // the timeout is enabled.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // Handshake and status flags decoded straight from the state register.
  assign cmd_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == TO_LAST);

  // Transfer sequencing, APB outputs and response registers.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state   <= ST_SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_write ? cmd_wdata : '0;
          end
        end
        ST_SETUP: begin
          state    <= ST_ACCESS;
          penable  <= 1'b1;
          wait_cnt <= '0;
        end
        ST_ACCESS: begin
          if (pready) begin
            state       <= ST_IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= pwrite ? '0 : prdata;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit) begin
              state       <= ST_IDLE;
              psel        <= 1'b0;
              penable     <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_rdata   <= '0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a byte-wide APB slave memory model.
module tb_apb_cmd_master;

  logic       pclk;
  logic       presetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       busy;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  logic       ovr_en;
  logic [7:0] ovr_val;
  logic [7:0] mem [0:255];

  int checks;
  int errors;

  apb_cmd_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(16), .CNT_W(8)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Slave model: write completes on the ACCESS edge that sees pready.
  assign prdata = ovr_en ? ovr_val : mem[paddr];
  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    step();
    step();
    checks++; if (psel !== 1'b0) begin errors++; $display("FAIL reset_psel got %b exp 0", psel); end
    checks++; if (penable !== 1'b0) begin errors++; $display("FAIL reset_penable got %b exp 0", penable); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready_busy got %b%b exp 10", cmd_ready, busy); end
    checks++; if (paddr !== 8'h00 || pwdata !== 8'h00 || pwrite !== 1'b0) begin errors++; $display("FAIL reset_bus got %h %h %b exp 00 00 0", paddr, pwdata, pwrite); end
    presetn = 1'b1;
    step();
  endtask

  task automatic test_write_zero_wait();
    pready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h03; cmd_wdata = 8'hA5;
    step();  // E0
    cmd_valid = 1'b0;
    checks++; if ({psel, penable, pwrite} !== 3'b101) begin errors++; $display("FAIL wr_setup got %b exp 101", {psel, penable, pwrite}); end
    checks++; if (paddr !== 8'h03 || pwdata !== 8'hA5) begin errors++; $display("FAIL wr_setup_bus got %h %h exp 03 a5", paddr, pwdata); end
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b%b exp 01", cmd_ready, busy); end
    step();  // E1
    checks++; if ({psel, penable, rsp_valid} !== 3'b110) begin errors++; $display("FAIL wr_access got %b exp 110", {psel, penable, rsp_valid}); end
    step();  // E2
    checks++; if ({psel, penable, rsp_valid} !== 3'b001) begin errors++; $display("FAIL wr_done got %b exp 001", {psel, penable, rsp_valid}); end
    checks++; if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 8'h00) begin errors++; $display("FAIL wr_rsp got %b %b %h exp 0 0 00", rsp_err, rsp_timeout, rsp_rdata); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_again got %b exp 1", cmd_ready); end
    checks++; if (mem[3] !== 8'hA5) begin errors++; $display("FAIL wr_slave_reg got %h exp a5", mem[3]); end
    step();  // E3
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_pulse_width got %b exp 0", rsp_valid); end
  endtask

  task automatic test_read();
    logic [7:0] addrs [2];
    logic [7:0] exps  [2];
    addrs[0] = 8'h03; exps[0] = 8'hA5;
    addrs[1] = 8'h09; exps[1] = 8'h00;
    pready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addrs[i]; cmd_wdata = 8'hFF;
      step();  // E0
      cmd_valid = 1'b0;
      checks++; if (pwrite !== 1'b0 || pwdata !== 8'h00 || paddr !== addrs[i]) begin errors++; $display("FAIL rd_setup[%0d] got %b %h %h exp 0 00 %h", i, pwrite, pwdata, paddr, addrs[i]); end
      step();
      step();  // E2
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exps[i] || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp[%0d] got %b %h %b exp 1 %h 0", i, rsp_valid, rsp_rdata, rsp_err, exps[i]); end
      step();
    end
  endtask

  task automatic test_wait_states();
    int en_cnt;
    int pulses;
    en_cnt = 0; pulses = 0;
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h11; cmd_wdata = 8'h5A;
    step();  // E0
    cmd_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();  // E1..E8
      if (penable === 1'b1) en_cnt++;
      if (rsp_valid === 1'b1) pulses++;
      if (penable === 1'b1 && (paddr !== 8'h11 || pwdata !== 8'h5A || psel !== 1'b1)) begin
        checks++; errors++;
        $display("FAIL ws_stable c%0d got %h %h %b exp 11 5a 1", c, paddr, pwdata, psel);
      end
      // Sample after E4 is the third wait cycle; release pready for E5.
      if (c == 3) pready = 1'b1;
    end
    checks++; if (en_cnt !== 4) begin errors++; $display("FAIL ws_penable_cycles got %0d exp 4", en_cnt); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ws_rsp_pulses got %0d exp 1", pulses); end
    checks++; if (mem[8'h11] !== 8'h5A) begin errors++; $display("FAIL ws_slave_reg got %h exp 5a", mem[8'h11]); end
  endtask

  task automatic test_slverr();
    pready = 1'b1; pslverr = 1'b1; ovr_en = 1'b1; ovr_val = 8'h3C;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; cmd_wdata = 8'h00;
    step();
    cmd_valid = 1'b0;
    step();
    step();  // E2
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL slverr_flags got %b %b %b exp 1 1 0", rsp_valid, rsp_err, rsp_timeout); end
    checks++; if (rsp_rdata !== 8'h3C) begin errors++; $display("FAIL slverr_rdata got %h exp 3c", rsp_rdata); end
    pslverr = 1'b0; ovr_en = 1'b0;
    step();
    checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 8'h3C) begin errors++; $display("FAIL rsp_hold got %b %h exp 1 3c", rsp_err, rsp_rdata); end
  endtask

  task automatic test_timeout();
    int done_at;
    int en_cnt;
    done_at = -1; en_cnt = 0;
    pready = 1'b0; ovr_en = 1'b1; ovr_val = 8'hEE;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h05; cmd_wdata = 8'h00;
    step();  // E0
    cmd_valid = 1'b0;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      step();
      if (penable === 1'b1) en_cnt++;
      if (rsp_valid === 1'b1) done_at = c;
    end
    checks++; if (done_at !== 17) begin errors++; $display("FAIL to_latency got %0d exp 17", done_at); end
    checks++; if (en_cnt !== 16) begin errors++; $display("FAIL to_access_cycles got %0d exp 16", en_cnt); end
    checks++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 8'h00) begin errors++; $display("FAIL to_rsp got %b %b %h exp 1 1 00", rsp_err, rsp_timeout, rsp_rdata); end
    checks++; if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_bus_idle got %b%b%b exp 000", psel, penable, busy); end
    ovr_en = 1'b0; pready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    pready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 8'h11;
    step();  // E0
    cmd_addr = 8'h41; cmd_wdata = 8'h22;
    step();  // E1
    checks++; if (paddr !== 8'h40 || pwdata !== 8'h11) begin errors++; $display("FAIL b2b_busy_ignore got %h %h exp 40 11", paddr, pwdata); end
    step();  // E2
    checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL b2b_first_done got %b %b %b exp 1 1 0", rsp_valid, cmd_ready, rsp_timeout); end
    step();  // E3
    cmd_valid = 1'b0;
    checks++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 8'h41 || pwdata !== 8'h22) begin errors++; $display("FAIL b2b_second_setup got %b %b %h %h exp 1 0 41 22", psel, penable, paddr, pwdata); end
    step();
    step();  // E5
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", rsp_valid); end
    checks++; if (mem[8'h40] !== 8'h11 || mem[8'h41] !== 8'h22) begin errors++; $display("FAIL b2b_slave_regs got %h %h exp 11 22", mem[8'h40], mem[8'h41]); end
    step();
  endtask

  task automatic test_reset_in_access();
    int pulses;
    pulses = 0;
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 8'h77;
    step();  // E0
    cmd_addr = 8'h44; cmd_wdata = 8'h99;
    step();  // E1, in ACCESS with cmd_valid still high
    step();
    checks++; if (penable !== 1'b1 || cmd_ready !== 1'b0 || paddr !== 8'h30) begin errors++; $display("FAIL rst_pre got %b %b %h exp 1 0 30", penable, cmd_ready, paddr); end
    presetn = 1'b0;
    step();
    checks++; if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_access got %b%b%b%b exp 0000", psel, penable, busy, rsp_valid); end
    checks++; if (paddr !== 8'h00 || pwdata !== 8'h00) begin errors++; $display("FAIL rst_access_bus got %h %h exp 00 00", paddr, pwdata); end
    cmd_valid = 1'b0; presetn = 1'b1; pready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (rsp_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0 || psel !== 1'b0) begin errors++; $display("FAIL rst_no_rsp got %0d %b exp 0 0", pulses, psel); end
    checks++; if (mem[8'h30] !== 8'h00 || mem[8'h44] !== 8'h00) begin errors++; $display("FAIL rst_no_write got %h %h exp 00 00", mem[8'h30], mem[8'h44]); end
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 8'h00; cmd_wdata = 8'h00;
    pready = 1'b1; pslverr = 1'b0; ovr_en = 1'b0; ovr_val = 8'h00;
    test_reset();
    test_write_zero_wait();
    test_read();
    test_wait_states();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_in_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
